// File: rtl/cmp_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : cmp_seq_pkg                                                     |
// | Purpose  : Shared state encoding and Q1.15 constants for the comparator    |
// |            seed sequencer.                                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package cmp_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      OUT     = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [15:0] Q15_MIN  = 16'h8000;
   localparam logic [15:0] Q15_ZERO = 16'h0000;
   localparam logic [15:0] Q15_MAX  = 16'h7FFF;

endpackage

`default_nettype wire

// File: rtl/cmp_seed_sequencer_vn_debias.sv
// +----------------------------------------------------------------------------+
// | Module   : vn_debias                                                       |
// | Purpose  : Von Neumann debiaser. Takes accepted bits in pairs:             |
// |            01 -> 0, 10 -> 1, 00/11 -> nothing.                             |
// | Ports    : clk, rst_n     clock, async active-low reset                    |
// |            clear          drop any pending first-of-pair bit               |
// |            in_valid/in_bit  incoming raw bit                               |
// |            emit_valid/emit_bit  debiased bit, same cycle as 2nd of pair    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module vn_debias (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic in_valid,
   input  logic in_bit,
   output logic emit_valid,
   output logic emit_bit
);

   logic have_first;
   logic first_bit;

   // Emission is combinational on the second bit of a pair so the packer
   // can consume it in the same cycle the completing sample is accepted.
   assign emit_valid = in_valid & have_first & (first_bit != in_bit);
   assign emit_bit   = first_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_first <= 1'b0;
         first_bit  <= 1'b0;
      end else if (clear) begin
         have_first <= 1'b0;
         first_bit  <= 1'b0;
      end else if (in_valid) begin
         have_first <= ~have_first;
         if (!have_first) begin
            first_bit <= in_bit;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cmp_seed_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : cmp_seed_sequencer                                              |
// | Purpose  : Compares signed Q1.15 samples against a threshold latched at    |
// |            start, packs the comparator bits MSB-first into WORD_W-bit      |
// |            words and emits NUM_WORDS words per run as LFSR seeds.          |
// | Ports    : clk, rst_n          clock, async active-low reset               |
// |            start, abort        run request / synchronous cancel            |
// |            thr                 threshold, latched on an accepted start     |
// |            in_valid/in_ready/in_data      sample handshake                 |
// |            out_valid/out_ready/out_word   word handshake                   |
// |            word_idx            index of the presented word                 |
// |            busy, done          run in progress / sticky run complete       |
// | Option   : CMP_SEQ_VN_DEBIAS_EN inserts a von Neumann debiaser between     |
// |            comparator and packer.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmp_seed_sequencer
   import cmp_seq_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [DATA_W-1:0]            thr,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WORD_W-1:0]            out_word,
   output logic [$clog2(NUM_WORDS):0]   word_idx,
   output logic                         busy,
   output logic                         done
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int IDX_W = $clog2(NUM_WORDS) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] thr_q;
   logic [WORD_W-1:0] sreg;
   logic [CNT_W-1:0]  bit_cnt;

   logic accept;
   logic cmp_bit;
   logic push;
   logic push_bit;
   logic word_done;
   logic out_fire;

   // in_ready is a pure state decode: no path from in_valid.
   assign in_ready  = (state == COLLECT);
   assign accept    = in_valid & in_ready;
   // Direct signed compare; no subtraction, so no overflow at the extremes.
   assign cmp_bit   = ($signed(in_data) >= $signed(thr_q));
   assign word_done = push & (bit_cnt == LAST_BIT);
   assign out_fire  = out_valid & out_ready;

`ifdef CMP_SEQ_VN_DEBIAS_EN
   logic pair_clear;
   assign pair_clear = abort
                     | (start & ((state == IDLE) | (state == DONE)))
                     | word_done;

   vn_debias u_vn_debias (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (pair_clear),
      .in_valid   (accept),
      .in_bit     (cmp_bit),
      .emit_valid (push),
      .emit_bit   (push_bit)
   );
`else
   assign push     = accept;
   assign push_bit = cmp_bit;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start)     state_next = COLLECT;
            COLLECT:    if (word_done) state_next = OUT;
            OUT:        if (out_fire)  state_next = (word_idx == LAST_IDX) ? DONE : COLLECT;
            default:                   state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         thr_q     <= '0;
         sreg      <= '0;
         bit_cnt   <= '0;
         word_idx  <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (abort) begin
         sreg      <= '0;
         bit_cnt   <= '0;
         word_idx  <= '0;
         out_word  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  thr_q    <= thr;
                  sreg     <= '0;
                  bit_cnt  <= '0;
                  word_idx <= '0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            COLLECT: begin
               if (push) begin
                  sreg <= {sreg[WORD_W-2:0], push_bit};
                  if (word_done) begin
                     out_word  <= {sreg[WORD_W-2:0], push_bit};
                     out_valid <= 1'b1;
                     bit_cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            OUT: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  if (word_idx == LAST_IDX) begin
                     done <= 1'b1;
                     busy <= 1'b0;
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmp_seed_sequencer.sv
`default_nettype none

module tb_cmp_seed_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] thr = 16'h0000;
   logic [15:0] in_data = 16'h0000;

   // dut_a: WORD_W=4, NUM_WORDS=2
   logic       a_in_ready, a_out_valid, a_busy, a_done;
   logic [3:0] a_out_word;
   logic [1:0] a_word_idx;
   // dut_b: WORD_W=4, NUM_WORDS=1
   logic       b_in_ready, b_out_valid, b_busy, b_done;
   logic [3:0] b_out_word;
   logic [0:0] b_word_idx;
   // dut_c: WORD_W=2, NUM_WORDS=1
   logic       c_in_ready, c_out_valid, c_busy, c_done;
   logic [1:0] c_out_word;
   logic [0:0] c_word_idx;

   always #5 clk = ~clk;

   cmp_seed_sequencer #(.DATA_W(16), .WORD_W(4), .NUM_WORDS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thr(thr),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_word(a_out_word),
      .word_idx(a_word_idx), .busy(a_busy), .done(a_done));

   cmp_seed_sequencer #(.DATA_W(16), .WORD_W(4), .NUM_WORDS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thr(thr),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_word(b_out_word),
      .word_idx(b_word_idx), .busy(b_busy), .done(b_done));

   cmp_seed_sequencer #(.DATA_W(16), .WORD_W(2), .NUM_WORDS(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .thr(thr),
      .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_word(c_out_word),
      .word_idx(c_word_idx), .busy(c_busy), .done(c_done));

   int total = 0;
   int bad   = 0;

   // Reference model for dut_a: queue of emitted bits for the current word.
   logic [15:0] thr_m = 16'h0000;
   bit          bq[$];
   bit          pend_v = 1'b0;
   bit          pend_b = 1'b0;
   int          widx_m = 0;

   typedef struct packed {
      logic [15:0]      thr;
      logic [15:0]      thr_run;
      logic [0:3][15:0] d;
      logic [3:0]       exp_word;
   } vec_t;

   vec_t vt[5];

   function automatic vec_t mkvec(input logic [15:0] t, input logic [15:0] tr,
                                  input logic [15:0] d0, input logic [15:0] d1,
                                  input logic [15:0] d2, input logic [15:0] d3,
                                  input logic [3:0] e);
      vec_t v;
      v.thr      = t;
      v.thr_run  = tr;
      v.d        = {d0, d1, d2, d3};
      v.exp_word = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out, got no completion, expected completion", name);
   endtask

   task automatic model_clear();
      bq.delete();
      pend_v = 1'b0;
      pend_b = 1'b0;
      widx_m = 0;
   endtask

   task automatic model_push(input logic [15:0] d, output bit complete, output logic [3:0] w);
      bit b;
      b = ($signed(d) >= $signed(thr_m));
      complete = 1'b0;
      w = 4'h0;
`ifdef CMP_SEQ_VN_DEBIAS_EN
      if (!pend_v) begin
         pend_v = 1'b1;
         pend_b = b;
      end else begin
         pend_v = 1'b0;
         if (pend_b != b) bq.push_back(pend_b);
      end
`else
      bq.push_back(b);
`endif
      if (bq.size() == 4) begin
         for (int i = 0; i < 4; i++) w = {w[2:0], bq[i]};
         complete = 1'b1;
         bq.delete();
         pend_v = 1'b0;
      end
   endtask

   function automatic logic rdy(input int k);
      case (k)
         0:       return a_in_ready;
         1:       return b_in_ready;
         default: return c_in_ready;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input int k, input logic [15:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!rdy(k) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail("send_ready");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] t);
      thr   = t;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      thr_m = t;
      model_clear();
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      model_clear();
   endtask

   function automatic logic [15:0] rnd_sample();
      case ($urandom_range(0, 5))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return thr_m;
         3:       return thr_m - 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic a_feed(input logic [15:0] d, output bit c, output logic [3:0] w);
      send(0, d);
      model_push(d, c, w);
      chk("a_out_valid_after_accept", {31'b0, a_out_valid}, {31'b0, c});
      if (c) begin
         chk("a_out_word", {28'b0, a_out_word}, {28'b0, w});
         chk("a_word_idx", {30'b0, a_word_idx}, widx_m);
      end
   endtask

   task automatic a_word(output logic [3:0] w);
      bit c;
      int n;
      c = 1'b0;
      n = 0;
      w = 4'h0;
      while (!c && n < 64) begin
         a_feed(rnd_sample(), c, w);
         n++;
      end
      if (!c) fail("a_word_complete");
   endtask

   task automatic a_drain(input logic [3:0] w, input int hold);
      out_ready = 1'b0;
      for (int n = 0; n < hold; n++) begin
         @(negedge clk);
         chk("hold_out_valid", {31'b0, a_out_valid}, 1);
         chk("hold_out_word", {28'b0, a_out_word}, {28'b0, w});
         chk("hold_word_idx", {30'b0, a_word_idx}, widx_m);
         chk("hold_in_ready", {31'b0, a_in_ready}, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_out_valid", {31'b0, a_out_valid}, 0);
      if (widx_m == 1) begin
         chk("drain_done", {31'b0, a_done}, 1);
         chk("drain_busy", {31'b0, a_busy}, 0);
      end else begin
         widx_m++;
         chk("drain_in_ready", {31'b0, a_in_ready}, 1);
         chk("drain_word_idx", {30'b0, a_word_idx}, widx_m);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] w;
      bit         c;
      logic [15:0] vn_s[8];

      vt[0] = mkvec(16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 4'b1010);
      vt[1] = mkvec(16'h4000, 16'h0000, 16'h3FFF, 16'h4000, 16'h8000, 16'h7FFF, 4'b0101);
      vt[2] = mkvec(16'h8000, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF, 16'h7FFF, 4'b1111);
      vt[3] = mkvec(16'h7FFF, 16'h8000, 16'h7FFE, 16'h7FFF, 16'h8000, 16'h0000, 4'b0100);
      vt[4] = mkvec(16'hFFFF, 16'h0000, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h8000, 4'b0110);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'b0, a_in_ready}, 0);
      chk("rst_out_valid", {31'b0, a_out_valid}, 0);
      chk("rst_busy", {31'b0, a_busy}, 0);
      chk("rst_done", {31'b0, a_done}, 0);
      chk("rst_out_word", {28'b0, a_out_word}, 0);
      chk("rst_word_idx", {30'b0, a_word_idx}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", {31'b0, a_in_ready}, 0);

      // Comparator vectors on the single-word instance
      for (int i = 0; i < 5; i++) begin
         do_abort();
         do_start(vt[i].thr);
         thr = vt[i].thr_run;
         chk("vec_busy", {31'b0, b_busy}, 1);
         chk("vec_in_ready", {31'b0, b_in_ready}, 1);
         for (int j = 0; j < 4; j++) send(1, vt[i].d[j]);
`ifdef CMP_SEQ_VN_DEBIAS_EN
         chk("vec_vn_out_valid", {31'b0, b_out_valid}, 0);
`else
         chk("vec_out_valid", {31'b0, b_out_valid}, 1);
         chk("vec_out_word", {28'b0, b_out_word}, {28'b0, vt[i].exp_word});
         chk("vec_word_idx", {31'b0, b_word_idx}, 0);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("vec_out_valid_clr", {31'b0, b_out_valid}, 0);
         chk("vec_done", {31'b0, b_done}, 1);
         chk("vec_busy_clr", {31'b0, b_busy}, 0);
`endif
      end

      // Debias pattern on the 2-bit instance: bits 1,1,0,1,0,0,1,0
      vn_s = '{16'h7FFF, 16'h0001, 16'h8000, 16'h1234, 16'hFFFF, 16'h8000, 16'h0000, 16'h8001};
      do_abort();
      do_start(16'h0000);
`ifdef CMP_SEQ_VN_DEBIAS_EN
      for (int i = 0; i < 8; i++) begin
         send(2, vn_s[i]);
         chk("vn_out_valid", {31'b0, c_out_valid}, (i == 7) ? 1 : 0);
      end
      chk("vn_out_word", {30'b0, c_out_word}, 2'b01);
`else
      send(2, vn_s[0]);
      chk("raw_out_valid_1", {31'b0, c_out_valid}, 0);
      send(2, vn_s[1]);
      chk("raw_out_valid_2", {31'b0, c_out_valid}, 1);
      chk("raw_out_word", {30'b0, c_out_word}, 2'b11);
`endif

      // Backpressure: hold the first word for 10 cycles, then a second word
      do_abort();
      do_start(16'h0000);
      a_word(w);
      a_drain(w, 10);
      a_word(w);
      a_drain(w, 2);

      // Reset asserted while a word is presented
      do_abort();
      do_start(16'h1000);
      a_word(w);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, a_out_valid}, 0);
      chk("arst_busy", {31'b0, a_busy}, 0);
      chk("arst_done", {31'b0, a_done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      chk("arst_in_ready", {31'b0, a_in_ready}, 0);
      chk("arst_word_idx", {30'b0, a_word_idx}, 0);
      chk("arst_out_word", {28'b0, a_out_word}, 0);

      // Abort and start together during COLLECT with 2 bits captured
      do_start(16'h0000);
      a_feed(16'h7FFF, c, w);
      a_feed(16'h0001, c, w);
      abort = 1'b1;
      start = 1'b1;
      thr   = 16'h7FFF;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      model_clear();
      chk("abort_busy", {31'b0, a_busy}, 0);
      chk("abort_in_ready", {31'b0, a_in_ready}, 0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_out_valid", {31'b0, a_out_valid}, 0);
         @(negedge clk);
      end
      do_start(16'h0000);
      a_word(w);
      a_drain(w, 1);
      a_word(w);
      a_drain(w, 0);

      // Randomized runs against the model
      for (int r = 0; r < 25; r++) begin
         logic [15:0] t;
         if ($urandom_range(0, 1) == 1) do_abort();
         case ($urandom_range(0, 3))
            0:       t = 16'h8000;
            1:       t = 16'h7FFF;
            2:       t = 16'h0000;
            default: t = 16'($urandom);
         endcase
         do_start(t);
         if ($urandom_range(0, 3) == 0) begin
            // start while busy must not re-latch the threshold
            thr   = 16'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         thr = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            int k;
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) a_feed(rnd_sample(), c, w);
            do_abort();
            chk("rnd_abort_busy", {31'b0, a_busy}, 0);
            chk("rnd_abort_out_valid", {31'b0, a_out_valid}, 0);
            chk("rnd_abort_in_ready", {31'b0, a_in_ready}, 0);
            do_start(t);
         end
         a_word(w);
         a_drain(w, $urandom_range(0, 3));
         a_word(w);
         a_drain(w, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
